pc_next_unit: RTL and testbench

Registered program-counter unit for the pipeline fetch stage, successor to the two-input PC select mux. Holds the current PC and chooses the next one from sequential increment, EX-stage branch redirect, ID-stage jump, call and return. Calls and returns use an internal circular return-address stack (RAS). It supports stall and signals a non-sequential load so the pipeline can flush.

---
 rtl/pc_next_if.sv | 28 ++
 rtl/pc_next_unit.sv | 90 +++++++++
 tb/tb_pc_next_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_next_if.sv
// Fetch-stage control bundle between the pipeline (master) and the PC unit (slave).
interface pc_next_if #(
  parameter int unsigned NBITS = 7
);
  logic             stall;
  logic             branch_taken;
  logic [NBITS-1:0] branch_target;
  logic             jump;
  logic             call;
  logic             ret;
  logic [NBITS-1:0] jump_target;
  logic [NBITS-1:0] ret_addr;
  logic [NBITS-1:0] pc;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, branch_taken, branch_target, jump, call, ret, jump_target, ret_addr,
    input  pc, redirect, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, call, ret, jump_target, ret_addr,
    output pc, redirect, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered next-PC selection with EX branch, ID jump/call/return and a
// circular return-address stack that overwrites its oldest entry when full.
module pc_next_unit #(
  parameter int unsigned     NBITS      = 7,
  parameter logic [NBITS-1:0] RESET_ADDR = '0,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input logic    clk,
  input logic    rst,
  pc_next_if.slave bus
);
  localparam int unsigned TPW = $clog2(RAS_DEPTH);
  localparam logic [TPW:0] CNT_MAX = (TPW + 1)'(RAS_DEPTH);

  logic [NBITS-1:0] pc_q, pc_d, pc_inc;
  logic [NBITS-1:0] ras [RAS_DEPTH];
  logic [TPW-1:0]   tp, tp_d;
  logic [TPW:0]     cnt, cnt_d;
  logic             push;
  logic             redirect_q, redirect_d;
  logic             underflow_q, underflow_d;

  assign pc_inc = pc_q + NBITS'(1);

  always_comb begin
    pc_d        = pc_q;
    tp_d        = tp;
    cnt_d       = cnt;
    push        = 1'b0;
    redirect_d  = 1'b0;
    underflow_d = 1'b0;
    // A taken branch squashes the same-cycle ID instruction, stall or not.
    if (bus.branch_taken) begin
      pc_d       = bus.branch_target;
      redirect_d = 1'b1;
    end else if (!bus.stall) begin
      if (bus.ret) begin
        if (cnt != '0) begin
          pc_d       = ras[tp];
          tp_d       = tp - TPW'(1);
          cnt_d      = cnt - (TPW + 1)'(1);
          redirect_d = 1'b1;
        end else begin
          pc_d        = pc_inc;
          underflow_d = 1'b1;
        end
      end else if (bus.call) begin
        push       = 1'b1;
        tp_d       = tp + TPW'(1);
        cnt_d      = (cnt == CNT_MAX) ? cnt : cnt + (TPW + 1)'(1);
        pc_d       = bus.jump_target;
        redirect_d = 1'b1;
      end else if (bus.jump) begin
        pc_d       = bus.jump_target;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_ADDR;
      tp          <= '0;
      cnt         <= '0;
      redirect_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      tp          <= tp_d;
      cnt         <= cnt_d;
      redirect_q  <= redirect_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents need no reset; cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras[tp_d] <= bus.ret_addr;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.redirect      = redirect_q;
  assign bus.ras_underflow = underflow_q;
  assign bus.ras_empty     = (cnt == '0);
  assign bus.ras_full      = (cnt == CNT_MAX);
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: increment/wrap, stall vs branch, RAS nesting,
// overflow/underflow, simultaneous controls and reset mid-operation.
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_next_if #(.NBITS(7)) bus ();

  pc_next_unit #(.NBITS(7), .RESET_ADDR(7'd0), .RAS_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic do_call(input int jt, input int ra);
    idle();
    bus.call = 1; bus.jump_target = 7'(jt); bus.ret_addr = 7'(ra);
    step();
    bus.call = 0;
  endtask

  task automatic do_ret();
    idle();
    bus.ret = 1;
    step();
    bus.ret = 0;
  endtask

  initial begin
    int redir_seen;
    idle();
    bus.branch_target = '0; bus.jump_target = '0; bus.ret_addr = '0;
    rst = 1;
    step();
    check("rst_pc", bus.pc, 0);
    check("rst_redirect", bus.redirect, 0);
    check("rst_empty", bus.ras_empty, 1);
    check("rst_full", bus.ras_full, 0);
    check("rst_underflow", bus.ras_underflow, 0);
    rst = 0;

    redir_seen = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      check("inc_pc", bus.pc, (i + 1) % 128);
      if (bus.redirect) redir_seen = 1;
      if (i == 127) check("wrap_pc", bus.pc, 0);
    end
    check("inc_redirect", redir_seen, 0);
    repeat (3) step();
    check("pc_5", bus.pc, 5);

    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.pc, 5);
      check("stall_redirect", bus.redirect, 0);
    end
    bus.jump = 1; bus.jump_target = 7'd99;
    step();
    check("stall_jump_pc", bus.pc, 5);
    check("stall_jump_redirect", bus.redirect, 0);
    bus.jump = 0;
    bus.branch_taken = 1; bus.branch_target = 7'd40;
    step();
    check("stall_branch_pc", bus.pc, 40);
    check("stall_branch_redirect", bus.redirect, 1);
    bus.branch_taken = 0;
    step();
    check("branch_hold_pc", bus.pc, 40);
    check("branch_redirect_pulse", bus.redirect, 0);
    idle();

    do_call(20, 3);
    check("call1_pc", bus.pc, 20);
    check("call1_redirect", bus.redirect, 1);
    check("call1_empty", bus.ras_empty, 0);
    do_call(30, 21);
    check("call2_pc", bus.pc, 30);
    do_ret();
    check("ret1_pc", bus.pc, 21);
    check("ret1_redirect", bus.redirect, 1);
    do_ret();
    check("ret2_pc", bus.pc, 3);
    check("nest_empty", bus.ras_empty, 1);

    for (int k = 1; k <= 5; k++) do_call(60 + k, k);
    check("ovf_pc", bus.pc, 65);
    check("ovf_full", bus.ras_full, 1);
    for (int k = 5; k >= 2; k--) begin
      do_ret();
      check("ovf_ret_pc", bus.pc, k);
    end
    check("ovf_full_clr", bus.ras_full, 0);
    check("ovf_empty", bus.ras_empty, 1);
    do_ret();
    check("udf_pc", bus.pc, 3);
    check("udf_flag", bus.ras_underflow, 1);
    check("udf_redirect", bus.redirect, 0);
    step();
    check("udf_pulse", bus.ras_underflow, 0);
    check("udf_next_pc", bus.pc, 4);

    idle();
    bus.branch_taken = 1; bus.branch_target = 7'd50;
    bus.call = 1; bus.jump_target = 7'd10; bus.ret_addr = 7'd7;
    step();
    check("br_call_pc", bus.pc, 50);
    check("br_call_empty", bus.ras_empty, 1);
    check("br_call_redirect", bus.redirect, 1);
    idle();
    do_call(70, 33);
    check("pre_retjmp_pc", bus.pc, 70);
    bus.ret = 1; bus.jump = 1; bus.jump_target = 7'd90;
    step();
    check("ret_jump_pc", bus.pc, 33);
    check("ret_jump_empty", bus.ras_empty, 1);
    idle();

    do_call(10, 11);
    do_call(12, 13);
    check("pre_rst_pc", bus.pc, 12);
    rst = 1; bus.ret = 1;
    step();
    check("midrst_pc", bus.pc, 0);
    check("midrst_empty", bus.ras_empty, 1);
    check("midrst_redirect", bus.redirect, 0);
    rst = 0;
    step();
    check("midrst_ret_pc", bus.pc, 1);
    check("midrst_underflow", bus.ras_underflow, 1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
